sha256_round_ctrl: RTL and testbench
====================================

// Module: sha256_round_ctrl
// PURPOSE
//  Sequencer for the hashcore round datapath. Accepts 512-bit padded message blocks over a
//  valid/ready handshake and generates Wt (16-word schedule window) and Kt (internal ROM).
//  Drives the hashcore through NUM_ROUNDS rounds, performs the final H += working-state add,
//  and presents the 256-bit digest with valid/ready. Sits between the padder and the top-level output.
// PARAMETERS
//  NUM_ROUNDS  64  rounds per block; must be 64 for SHA-256 (smaller values: debug only, <=64)
// PORTS
//  clk           in   1    clock; all logic on rising edge
//  rst           in   1    synchronous, active-high reset
//  blk_valid     in   1    blk_data/blk_first valid
//  blk_ready     out  1    controller can accept a block (high only in IDLE)
//  blk_data      in   512  padded block; word 0 = blk_data[511:480] (big-endian)
//  blk_first     in   1    1: chain from IV; 0: chain from previous digest
//  core_load     out  1    1-cycle pulse: hashcore loads core_init into a..h
//  core_round_en out  1    hashcore performs one round this cycle
//  core_kt       out  32   round constant K[round_cnt]
//  core_wt       out  32   schedule word W[round_cnt]
//  core_init     out  256  {A..H} initial working state (A in [255:224])
//  core_state    in   256  {A..H} current hashcore working state
//  round_cnt     out  6    current round index, 0..NUM_ROUNDS-1
//  busy          out  1    high in LOAD, ROUND and FINAL
//  digest        out  256  H0..H7, H0 in [255:224]
//  digest_valid  out  1    digest valid; held until digest_ready
//  digest_ready  in   1    downstream accepts digest
// BEHAVIOUR
//  - Reset: FSM->IDLE; H_cur<=IV (6a09e667..5be0cd19); round_cnt=0; W window=0.
//    All outputs 0 except blk_ready=1. Reset wins over every other event, including mid-block.
//  - FSM states: IDLE, LOAD, ROUND, FINAL, DONE.
//  - IDLE: blk_ready=1. On blk_valid&blk_ready:
//      capture blk_data into W window W[0..15];
//      if blk_first, H_cur<=IV; go LOAD.
//  - LOAD (1 cycle): core_load=1, core_init=H_cur, core_round_en=0, then ROUND.
//  - ROUND (NUM_ROUNDS cycles):
//      core_round_en=1, core_kt=K[round_cnt], core_wt=window[0].
//      Window shifts left one word per cycle; the new word[15] =
//        s1(w[14]) + w[9] + s0(w[1]) + w[0], mod 2^32, with
//        s0 = ROTR7 ^ ROTR18 ^ SHR3 and s1 = ROTR17 ^ ROTR19 ^ SHR10.
//      round_cnt increments. At round_cnt==NUM_ROUNDS-1, go FINAL with round_cnt<=0.
//  - FINAL (1 cycle): H_cur[i] <= H_cur[i] + core_state word i, each mod 2^32, no carry
//    between words; go DONE.
//  - DONE: digest=H_cur, digest_valid=1. On digest_ready, go IDLE.
//    digest stays stable while valid and keeps its value after the handshake.
//    blk_ready=0 in DONE (no accept in the same cycle as the digest handshake).
//  - Latency: accept edge at cycle T -> LOAD T+1, ROUND T+2..T+65, FINAL T+66,
//    digest_valid from T+67.
//  - blk_valid while busy/DONE: ignored; blk_data is not sampled.
//  - blk_first=0 on the first block after reset chains from IV, since H_cur was reset to IV.
//  - core_kt/core_wt/core_round_en are 0 outside ROUND; core_init is 0 outside LOAD.
// TESTING
//  1 "abc" single padded block, blk_first=1 -> digest
//    ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; digest_valid at T+67.
//  2 empty-message padded block, blk_first=1 -> digest
//    e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
//  3 "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" as 2 blocks
//    (first=1, then first=0) -> final digest
//    248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//  4 Backpressure: digest_ready low 10 cycles -> digest and digest_valid stable, blk_ready=0;
//    IDLE one cycle after the ready handshake.
//  5 Reset at round_cnt=30 -> next cycle: IDLE, blk_ready=1, all other outputs 0;
//    a subsequent "abc" block still gives the test-1 digest.
//  6 blk_valid held high through a whole block -> exactly one accept per block;
//    core_round_en high exactly 64 cycles per block; core_kt = 428a2f98 at round 0
//    and c67178f2 at round 63.

Source files
------------

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer: accepts padded blocks, expands the message schedule,
// feeds K/W to an external hashcore and folds its final state into the chaining value.
module sha256_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    output logic         core_load,
    output logic         core_round_en,
    output logic [31:0]  core_kt,
    output logic [31:0]  core_wt,
    output logic [255:0] core_init,
    input  logic [255:0] core_state,
    output logic [5:0]   round_cnt,
    output logic         busy,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t        state_q, state_d;
    logic [255:0]  h_q, h_d;
    logic [511:0]  w_q, w_d;
    logic [5:0]    round_q, round_d;
    logic [255:0]  digest_q, digest_d;
    logic [31:0]   w_new;

    // Word i of the window lives at w_q[511-32*i -: 32]; word 0 is the current Wt.
    always_comb begin
        w_new = sig1(w_q[63:32]) + w_q[223:192] + sig0(w_q[479:448]) + w_q[511:480];
    end

    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        w_d           = w_q;
        round_d       = round_q;
        digest_d      = digest_q;
        blk_ready     = 1'b0;
        core_load     = 1'b0;
        core_round_en = 1'b0;
        core_kt       = '0;
        core_wt       = '0;
        core_init     = '0;
        busy          = 1'b0;
        digest_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    w_d = blk_data;
                    if (blk_first) begin
                        h_d = IV;
                    end
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                core_load = 1'b1;
                core_init = h_q;
                state_d   = S_ROUND;
            end
            S_ROUND: begin
                busy          = 1'b1;
                core_round_en = 1'b1;
                core_kt       = K_ROM[round_q];
                core_wt       = w_q[511:480];
                w_d           = {w_q[479:0], w_new};
                if (round_q == LAST_ROUND) begin
                    round_d = '0;
                    state_d = S_FINAL;
                end else begin
                    round_d = round_q + 6'd1;
                end
            end
            S_FINAL: begin
                busy = 1'b1;
                // Eight independent 32-bit adds: no carry crosses a word boundary.
                for (int unsigned i = 0; i < 8; i++) begin
                    h_d[255 - 32*i -: 32] = h_q[255 - 32*i -: 32] + core_state[255 - 32*i -: 32];
                end
                digest_d = h_d;
                state_d  = S_DONE;
            end
            S_DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            h_q      <= IV;
            w_q      <= '0;
            round_q  <= '0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            w_q      <= w_d;
            round_q  <= round_d;
            digest_q <= digest_d;
        end
    end

    assign round_cnt = round_q;
    assign digest    = digest_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl with a behavioural hashcore round model.
module tb_sha256_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         core_load;
    logic         core_round_en;
    logic [31:0]  core_kt;
    logic [31:0]  core_wt;
    logic [255:0] core_init;
    logic [255:0] core_state;
    logic [5:0]   round_cnt;
    logic         busy;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready;

    always #5 clk = ~clk;

    sha256_round_ctrl #(.NUM_ROUNDS(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .blk_data      (blk_data),
        .blk_first     (blk_first),
        .core_load     (core_load),
        .core_round_en (core_round_en),
        .core_kt       (core_kt),
        .core_wt       (core_wt),
        .core_init     (core_init),
        .core_state    (core_state),
        .round_cnt     (round_cnt),
        .busy          (busy),
        .digest        (digest),
        .digest_valid  (digest_valid),
        .digest_ready  (digest_ready)
    );

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_M1    = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] BLK_M2    = {480'h0, 32'h000001c0};

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_M     = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] hc_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Hashcore stand-in: loads on core_load, performs one compression round per core_round_en.
    logic [255:0] hc_q;
    always @(posedge clk) begin
        if (rst) hc_q <= '0;
        else if (core_load) hc_q <= core_init;
        else if (core_round_en) hc_q <= hc_round(hc_q, core_kt, core_wt);
    end
    assign core_state = hc_q;

    typedef struct {
        logic [255:0] d;
        bit           care;
    } exp_t;

    exp_t        exp_q [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          accept_cnt = 0;
    int          round_en_cnt = 0;
    int          idle_leak = 0;
    logic [31:0] kt_first = '0;
    logic [31:0] kt_last = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Monitor: pops the scoreboard on every digest handshake and tracks core activity.
    always @(negedge clk) begin
        if (!rst) begin
            if (blk_valid && blk_ready) accept_cnt++;
            if (core_round_en) begin
                round_en_cnt++;
                if (round_cnt == 6'd0) kt_first = core_kt;
                if (round_cnt == 6'd63) kt_last = core_kt;
            end else if (core_kt != '0 || core_wt != '0) begin
                idle_leak++;
            end
            if (!core_load && core_init != '0) idle_leak++;
            if (digest_valid && digest_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_digest: got %h required none", digest);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.care) check("digest", digest, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [255:0] d, input bit care);
        exp_t e;
        e.d = d;
        e.care = care;
        exp_q.push_back(e);
    endtask

    task automatic start_block(input logic [511:0] data, input logic first, input bit hold);
        int n;
        n = 0;
        blk_data  = data;
        blk_first = first;
        blk_valid = 1'b1;
        while (!blk_ready && n < 200) begin
            tick();
            n++;
        end
        check("accept_ready", 256'(blk_ready), 256'(1));
        tick();
        if (!hold) blk_valid = 1'b0;
    endtask

    task automatic wait_digest(input string name);
        int n;
        n = 0;
        while (!digest_valid && n < 300) begin
            tick();
            n++;
        end
        check({"latency_", name}, 256'(n), 256'(66));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_blk_ready"}, 256'(blk_ready), 256'(1));
        check({tag, "_ctrl_zero"},
              256'({busy, digest_valid, core_load, core_round_en, core_kt, core_wt, round_cnt}), '0);
        check({tag, "_init_zero"}, core_init, '0);
        check({tag, "_digest_zero"}, digest, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d0;
        int stable, acc0, re0, n;

        rst = 1'b1;
        blk_valid = 1'b0;
        blk_data = '0;
        blk_first = 1'b0;
        digest_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        push_exp(D_ABC, 1'b1);
        start_block(BLK_ABC, 1'b1, 1'b0);
        wait_digest("abc");
        tick();
        check("idle_after_abc", 256'(blk_ready), 256'(1));

        push_exp(D_EMPTY, 1'b1);
        start_block(BLK_EMPTY, 1'b1, 1'b0);
        wait_digest("empty");
        tick();

        // Intermediate chaining value is not checked directly; the final digest depends on it.
        push_exp('0, 1'b0);
        start_block(BLK_M1, 1'b1, 1'b0);
        wait_digest("m1");
        tick();
        push_exp(D_M, 1'b1);
        start_block(BLK_M2, 1'b0, 1'b0);
        wait_digest("m2");
        tick();

        digest_ready = 1'b0;
        push_exp(D_ABC, 1'b1);
        start_block(BLK_ABC, 1'b1, 1'b0);
        wait_digest("bp");
        d0 = digest;
        blk_data = BLK_EMPTY;
        blk_first = 1'b1;
        blk_valid = 1'b1;
        acc0 = accept_cnt;
        stable = 0;
        repeat (10) begin
            tick();
            if (digest_valid && digest === d0 && !blk_ready) stable++;
        end
        check("bp_stable_cycles", 256'(stable), 256'(10));
        check("bp_no_accept", 256'(accept_cnt - acc0), 256'(0));
        blk_valid = 1'b0;
        digest_ready = 1'b1;
        tick();
        check("bp_idle_after_hs", 256'({blk_ready, digest_valid, busy}), 256'(3'b100));
        check("bp_digest_held", digest, d0);

        start_block(BLK_ABC, 1'b1, 1'b0);
        n = 0;
        while (round_cnt != 6'd30 && n < 100) begin
            tick();
            n++;
        end
        check("reach_round30", 256'(round_cnt), 256'(30));
        rst = 1'b1;
        tick();
        check_reset_outputs("midreset");
        rst = 1'b0;
        tick();
        push_exp(D_ABC, 1'b1);
        start_block(BLK_ABC, 1'b0, 1'b0);
        wait_digest("abc_after_reset");
        tick();

        acc0 = accept_cnt;
        re0 = round_en_cnt;
        push_exp(D_EMPTY, 1'b1);
        start_block(BLK_EMPTY, 1'b1, 1'b1);
        wait_digest("hold");
        tick();
        blk_valid = 1'b0;
        tick();
        check("hold_one_accept", 256'(accept_cnt - acc0), 256'(1));
        check("hold_round_en_64", 256'(round_en_cnt - re0), 256'(64));
        check("kt_round0", 256'(kt_first), 256'(32'h428a2f98));
        check("kt_round63", 256'(kt_last), 256'(32'hc67178f2));

        check("idle_outputs_zero", 256'(idle_leak), 256'(0));
        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
